// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

    localparam int unsigned UART_TX_FIFO_DEPTH = 16;
    localparam int unsigned UART_CLKS_PER_BIT  = 234;
    localparam int unsigned UART_FRAME_BITS    = 10;
    localparam int unsigned UART_BYTE_W        = 8;

    // Scheduler states: IDLE may pop a byte, WAIT spaces the next write.
    typedef enum logic {
        UTS_IDLE = 1'b0,
        UTS_WAIT = 1'b1
    } uts_state_e;

    // Write strobe and byte presented to the uart transmitter.
    typedef struct packed {
        logic                   wr;
        logic [UART_BYTE_W-1:0] dat;
    } uart_tx_t;

    // Spacing counter width; holds values up to byte_cycles-1, at least one bit.
    function automatic int unsigned uts_cnt_w(input int unsigned byte_cycles);
        return (byte_cycles < 2) ? 1 : $clog2(byte_cycles);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Store-side handshake and uart-side outputs of the transmit scheduler.
interface uart_tx_scheduler_if
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH
) ();

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                   st_valid;
    logic [UART_BYTE_W-1:0] st_data;
    logic                   st_ready;
    logic                   stall;
    logic                   uart_wr;
    logic [UART_BYTE_W-1:0] uart_dat;
    logic [LVL_W-1:0]       level;
    logic                   idle;

    // Pipeline side: issues stores, observes flow control and status.
    modport master (
        output st_valid, st_data,
        input  st_ready, stall, uart_wr, uart_dat, level, idle
    );

    // Scheduler side.
    modport slave (
        input  st_valid, st_data,
        output st_ready, stall, uart_wr, uart_dat, level, idle
    );

endinterface

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop are ignored when full/empty.
module uart_tx_scheduler_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointer and occupancy next state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues UART stores and feeds the uart one byte per frame time.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH        = UART_TX_FIFO_DEPTH,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FRAME_BITS   = UART_FRAME_BITS,
    parameter int unsigned BYTE_CYCLES  = CLKS_PER_BIT * FRAME_BITS
) (
    input  logic               clk,
    input  logic               nrst,
    uart_tx_scheduler_if.slave bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = uts_cnt_w(BYTE_CYCLES);

    uts_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    uart_tx_t               tx_q, tx_d;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_BYTE_W-1:0] head;
    logic [LVL_W-1:0]       level;

    // Ready depends only on registered occupancy, so a full FIFO stays closed on a pop edge.
    assign push         = bus.st_valid & ~fifo_full;
    assign bus.st_ready = ~fifo_full;
    assign bus.stall    = bus.st_valid & fifo_full;
    assign bus.uart_wr  = tx_q.wr;
    assign bus.uart_dat = tx_q.dat;
    assign bus.level    = level;
    assign bus.idle     = fifo_empty & (state_q == UTS_IDLE);

    uart_tx_scheduler_sync_fifo #(
        .WIDTH (UART_BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (push),
        .din_i   (bus.st_data),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pop a byte in IDLE, then hold off for BYTE_CYCLES cycles in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        tx_d.wr = 1'b0;
        pop     = 1'b0;
        case (state_q)
            UTS_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    tx_d.wr  = 1'b1;
                    tx_d.dat = head;
                    cnt_d    = CNT_W'(BYTE_CYCLES - 1);
                    state_d  = UTS_WAIT;
                end
            end
            UTS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = UTS_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = UTS_IDLE;
        endcase
    end

    // State, spacing counter and registered uart outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= UTS_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: DUT A (DEPTH=4, BYTE_CYCLES=8), DUT B (BYTE_CYCLES=1).
module tb_uart_tx_scheduler;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    typedef struct {
        int         cyc;
        logic [7:0] dat;
    } strobe_t;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       stall;
        logic       wr;
        logic [7:0] dat;
        logic [2:0] level;
        logic       idle;
    } vec_t;

    strobe_t qa[$];
    strobe_t qb[$];
    logic    prev_wr_a = 1'b0;
    logic    prev_wr_b = 1'b0;
    vec_t    vecs[11];

    uart_tx_scheduler_if #(.DEPTH(4)) bus_a ();
    uart_tx_scheduler_if #(.DEPTH(4)) bus_b ();

    uart_tx_scheduler #(.DEPTH(4), .BYTE_CYCLES(8)) dut_a (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_a)
    );

    uart_tx_scheduler #(.DEPTH(4), .BYTE_CYCLES(1)) dut_b (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitors: log every strobe and require it to last exactly one cycle.
    always @(negedge clk) begin
        if (bus_a.uart_wr === 1'b1) begin
            check("a_wr_single_cycle", 32'(prev_wr_a), 32'd0);
            qa.push_back('{cyc, bus_a.uart_dat});
        end
        prev_wr_a <= bus_a.uart_wr;
    end

    always @(negedge clk) begin
        if (bus_b.uart_wr === 1'b1) begin
            check("b_wr_single_cycle", 32'(prev_wr_b), 32'd0);
            qb.push_back('{cyc, bus_b.uart_dat});
        end
        prev_wr_b <= bus_b.uart_wr;
    end

    // Called just after a negedge drive; waits until DUT A reports idle, tracking peak level.
    task automatic drain_a(input int budget, output int maxl, output bit ok);
        maxl = 0;
        ok   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #1;
            if (int'(bus_a.level) > maxl) maxl = int'(bus_a.level);
            if (bus_a.idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_order_a(input string name, input logic [7:0] exp [6], input int n);
        check({name, "_count"}, 32'(qa.size()), 32'(n));
        if (qa.size() >= n) begin
            for (int i = 0; i < n; i++)
                check($sformatf("%s_byte%0d", name, i), 32'(qa[i].dat), 32'(exp[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         maxl;
        bit         ok;
        int         sent;
        int         stalls;
        logic [7:0] exp6 [6];

        bus_a.st_valid = 1'b0;
        bus_a.st_data  = 8'h00;
        bus_b.st_valid = 1'b0;
        bus_b.st_data  = 8'h00;

        // Reset values while nrst is held low.
        #2;
        check("rst_ready", 32'(bus_a.st_ready), 32'd1);
        check("rst_idle",  32'(bus_a.idle),     32'd1);
        check("rst_level", 32'(bus_a.level),    32'd0);
        check("rst_wr",    32'(bus_a.uart_wr),  32'd0);
        check("rst_dat",   32'(bus_a.uart_dat), 32'd0);
        #20 nrst = 1'b1;

        // Test 1: single store, cycle-by-cycle table.
        vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 3'd0, 1'b0};
        for (int i = 3; i < 10; i++)
            vecs[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h41, 3'd0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus_a.st_valid = vecs[i].valid;
            bus_a.st_data  = vecs[i].data;
            #1;
            check($sformatf("t1_r%0d_ready", i), 32'(bus_a.st_ready), 32'(vecs[i].ready));
            check($sformatf("t1_r%0d_stall", i), 32'(bus_a.stall),    32'(vecs[i].stall));
            check($sformatf("t1_r%0d_wr", i),    32'(bus_a.uart_wr),  32'(vecs[i].wr));
            check($sformatf("t1_r%0d_dat", i),   32'(bus_a.uart_dat), 32'(vecs[i].dat));
            check($sformatf("t1_r%0d_level", i), 32'(bus_a.level),    32'(vecs[i].level));
            check($sformatf("t1_r%0d_idle", i),  32'(bus_a.idle),     32'(vecs[i].idle));
        end

        // Test 2: three-byte burst, order, spacing and peak level.
        #2 qa.delete();
        @(negedge clk); bus_a.st_valid = 1'b1; bus_a.st_data = 8'h48;
        @(negedge clk); bus_a.st_data = 8'h69;
        @(negedge clk); bus_a.st_data = 8'h21;
        @(negedge clk); bus_a.st_valid = 1'b0;
        drain_a(100, maxl, ok);
        check("t2_drained", 32'(ok), 32'd1);
        check("t2_peak_level", 32'(maxl), 32'd2);
        exp6 = '{8'h48, 8'h69, 8'h21, 8'h00, 8'h00, 8'h00};
        check_order_a("t2_order", exp6, 3);
        if (qa.size() >= 3) begin
            check("t2_gap01", 32'(qa[1].cyc - qa[0].cyc), 32'd9);
            check("t2_gap12", 32'(qa[2].cyc - qa[1].cyc), 32'd9);
        end

        // Test 3: six back-to-back stores into a four-entry FIFO.
        #2 qa.delete();
        sent   = 0;
        stalls = 0;
        maxl   = 0;
        for (int c = 0; c < 200 && sent < 6; c++) begin
            @(negedge clk);
            bus_a.st_valid = 1'b1;
            bus_a.st_data  = 8'(8'h10 + sent);
            #1;
            if (int'(bus_a.level) > maxl) maxl = int'(bus_a.level);
            if (bus_a.st_ready === 1'b1) begin
                sent++;
            end else begin
                stalls++;
                check("t3_stall_when_full", 32'(bus_a.stall), 32'd1);
            end
        end
        @(negedge clk); bus_a.st_valid = 1'b0;
        check("t3_all_accepted", 32'(sent), 32'd6);
        check("t3_stall_cycles", 32'(stalls), 32'd6);
        check("t3_max_level", 32'(maxl), 32'd4);
        drain_a(200, maxl, ok);
        check("t3_drained", 32'(ok), 32'd1);
        exp6 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_order_a("t3_order", exp6, 6);

        // Test 4: full FIFO on the IDLE pop edge gets no pass-through.
        #2 qa.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); bus_a.st_valid = 1'b1; bus_a.st_data = 8'(8'hA0 + k);
        end
        @(negedge clk); bus_a.st_data = 8'h55;
        #1;
        check("t4_full_level", 32'(bus_a.level), 32'd4);
        check("t4_full_ready", 32'(bus_a.st_ready), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("t4_popedge_ready", 32'(bus_a.st_ready), 32'd0);
        check("t4_popedge_stall", 32'(bus_a.stall), 32'd1);
        check("t4_popedge_wr", 32'(bus_a.uart_wr), 32'd0);
        @(negedge clk);
        #1;
        check("t4_after_pop_wr", 32'(bus_a.uart_wr), 32'd1);
        check("t4_after_pop_dat", 32'(bus_a.uart_dat), 32'hA1);
        check("t4_after_pop_level", 32'(bus_a.level), 32'd3);
        check("t4_after_pop_ready", 32'(bus_a.st_ready), 32'd1);
        @(negedge clk); bus_a.st_valid = 1'b0;
        #1;
        check("t4_refill_level", 32'(bus_a.level), 32'd4);
        drain_a(200, maxl, ok);
        check("t4_drained", 32'(ok), 32'd1);
        exp6 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h55};
        check_order_a("t4_order", exp6, 6);

        // Test 5: asynchronous reset during WAIT with bytes queued.
        #2 qa.delete();
        @(negedge clk); bus_a.st_valid = 1'b1; bus_a.st_data = 8'h31;
        @(negedge clk); bus_a.st_data = 8'h32;
        @(negedge clk); bus_a.st_data = 8'h33;
        @(negedge clk); bus_a.st_valid = 1'b0;
        #1;
        check("t5_pre_level", 32'(bus_a.level), 32'd2);
        #1 nrst = 1'b0;
        #1;
        check("t5_rst_wr", 32'(bus_a.uart_wr), 32'd0);
        check("t5_rst_dat", 32'(bus_a.uart_dat), 32'd0);
        check("t5_rst_level", 32'(bus_a.level), 32'd0);
        check("t5_rst_idle", 32'(bus_a.idle), 32'd1);
        check("t5_rst_ready", 32'(bus_a.st_ready), 32'd1);
        qa.delete();
        repeat (2) @(negedge clk);
        #2 nrst = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("t5_no_strobes", 32'(qa.size()), 32'd0);
        check("t5_level", 32'(bus_a.level), 32'd0);
        check("t5_idle", 32'(bus_a.idle), 32'd1);

        // Test 6: BYTE_CYCLES=1 gives strobes two cycles apart.
        #2 qb.delete();
        @(negedge clk); bus_b.st_valid = 1'b1; bus_b.st_data = 8'hC1;
        @(negedge clk); bus_b.st_data = 8'hC2;
        @(negedge clk); bus_b.st_data = 8'hC3;
        @(negedge clk); bus_b.st_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus_b.idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_drained", 32'(ok), 32'd1);
        check("t6_count", 32'(qb.size()), 32'd3);
        if (qb.size() >= 3) begin
            check("t6_byte0", 32'(qb[0].dat), 32'hC1);
            check("t6_byte1", 32'(qb[1].dat), 32'hC2);
            check("t6_byte2", 32'(qb[2].dat), 32'hC3);
            check("t6_gap01", 32'(qb[1].cyc - qb[0].cyc), 32'd2);
            check("t6_gap12", 32'(qb[2].cyc - qb[1].cyc), 32'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Sits between the MA-stage store path and the uart transmitter. Stores to UART_ADDR are captured into a small FIFO. Bytes are issued to the uart one at a time, spaced so that a byte is never written while the previous frame is still shifting out. It raises a stall toward the pipeline when the FIFO is full, and reports idle so that halt can wait for output to drain.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
CLKS_PER_BIT, 234, sysclk cycles per UART bit; must match the uart module setting
FRAME_BITS, 10, bits per frame (start + 8 data + stop)
BYTE_CYCLES, CLKS_PER_BIT*FRAME_BITS, cycles reserved per byte after each uart write

Ports:
clk  in  1  system clock; single clock domain, rising edge
nrst  in  1  asynchronous active-low reset
st_valid  in  1  MA-stage store to UART_ADDR this cycle
st_data  in  8  byte to send (mem_write_value[7:0])
st_ready  out  1  FIFO can accept; when st_valid=1 and st_ready=0 the pipeline must hold MA
stall  out  1  st_valid & ~st_ready
uart_wr  out  1  one-cycle write strobe to uart_wr_i
uart_dat  out  8  byte to uart_dat_i, valid while uart_wr=1
level  out  $clog2(DEPTH)+1  current FIFO occupancy
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (nrst=0, asynchronous): FIFO pointers=0, level=0, FSM=IDLE, wait counter=0, uart_wr=0, uart_dat=0, st_ready=1, idle=1. Reset asserted mid-frame discards queued bytes and aborts the spacing wait. A partially sent frame is the uart's concern.
- Push: occurs when st_valid & st_ready at a rising edge. The byte is written at wr_ptr, wr_ptr+1 (wraps mod DEPTH), level+1.
- st_ready = (level != DEPTH). This is combinational from registered level only. A pop in the same cycle does not make a full FIFO ready (no pass-through).
- FSM states:
  - IDLE: if level != 0, pop the head at this edge. Register uart_dat=head, uart_wr=1, load counter=BYTE_CYCLES-1, go to WAIT.
  - WAIT: uart_wr=0. Decrement counter each cycle. When counter==0, return to IDLE.
- Latency: a store pushed into an empty FIFO with FSM in IDLE at edge N gives uart_wr=1 during the cycle after edge N+1 (2 cycles store to strobe).
- Spacing: consecutive uart_wr rising edges are exactly BYTE_CYCLES+1 cycles apart when the FIFO stays non-empty (BYTE_CYCLES in WAIT plus one IDLE pop cycle).
- uart_wr is high for exactly one cycle per byte. uart_dat holds the last sent byte otherwise.
- Simultaneous push and pop: both performed, level unchanged, pointer updates independent.
- Full: pushes refused (stall=1). No byte is lost or overwritten. level never exceeds DEPTH.
- Empty in IDLE: no strobe, idle=1.
- idle=1 only when level==0 and state==IDLE. The CPU halt/finish logic waits for idle.
- Byte order is strict FIFO.

Decomposition:
- Add to define.v: UTS_IDLE / UTS_WAIT state encodings (1 bit) and UART_TX_FIFO_DEPTH default. Reuse existing UART_ADDR, ENABLE, DISABLE.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/level/full/empty, async active-low reset). The scheduler FSM and spacing counter stay in uart_tx_scheduler.

Test Plan:
Bench parameters are DEPTH=4, BYTE_CYCLES=8 unless a scenario says otherwise.
1. Single store: push 0x41 at edge 0 from reset -> uart_wr=1 with uart_dat=0x41 for one cycle after edge 1; idle returns to 1 after 8 WAIT cycles.
2. Burst: push 0x48,0x69,0x21 on 3 consecutive cycles -> three strobes in order 0x48,0x69,0x21, strobe edges 9 cycles apart; level peaks at 2 (first byte already popped).
3. Full/stall: push 6 bytes back-to-back -> st_ready drops once level=4, stall=1 while st_valid held. Every byte is eventually sent once in order, and none is dropped.
4. Simultaneous push/pop: level=4, hold st_valid with 0x55 on the IDLE pop edge -> push refused that cycle (no pass-through), accepted next cycle, level returns to 4.
5. Reset mid-operation: queue 3 bytes, drop nrst asynchronously between clock edges during WAIT -> outputs immediately take reset values. After release, no further strobes occur, level=0, idle=1.
6. Spacing check: BYTE_CYCLES=1 -> back-to-back bytes give strobes exactly 2 cycles apart; uart_wr is never high on 2 consecutive cycles.
